// File: rtl/tl45_decode_skid.sv
// Decode stage behind the prefetch unit: registers {pc, inst}, splits fields, extends the
// immediate, and uses a 1-entry skid buffer so the stall back to fetch is a pure flop.
module tl45_decode_skid #(
    parameter logic [4:0] OP_ILLEGAL_MIN    = 5'h18,
    parameter bit         BUBBLE_ON_ILLEGAL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_stall,
    input  logic [31:0] i_buf_pc,
    input  logic [31:0] i_buf_inst,
    output logic        o_dr_valid,
    output logic [31:0] o_dr_pc,
    output logic [4:0]  o_dr_opcode,
    output logic        o_dr_imode,
    output logic [3:0]  o_dr_dr,
    output logic [3:0]  o_dr_sr1,
    output logic [3:0]  o_dr_sr2,
    output logic [31:0] o_dr_imm32,
    output logic        o_dr_illegal
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic        imode;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm32;
        logic        illegal;
    } dec_t;

    typedef enum logic {
        EMPTY_SKID,
        FULL_SKID
    } state_t;

    state_t state, state_next;
    dec_t   out_q, out_next;
    dec_t   skid_q, skid_next;
    dec_t   dec_in;
    logic   stall_q, stall_next;
    logic   in_valid;

    // A bubble decodes to all-zero so it can never leak stale fields downstream.
    function automatic dec_t decode(input logic [31:0] pc, input logic [31:0] inst);
        dec_t d;
        logic is_illegal;
        d          = '0;
        is_illegal = (inst[31:27] >= OP_ILLEGAL_MIN);
        if ((inst != '0) && !(BUBBLE_ON_ILLEGAL && is_illegal)) begin
            d.valid   = 1'b1;
            d.pc      = pc;
            d.opcode  = inst[31:27];
            d.imode   = inst[26];
            d.dr      = inst[25:22];
            d.sr1     = inst[21:18];
            d.illegal = is_illegal;
            if (inst[26]) begin
                d.sr2 = 4'h0;
                case (inst[17:16])
                    2'b01:   d.imm32 = {{16{inst[15]}}, inst[15:0]};
                    2'b10:   d.imm32 = {inst[15:0], 16'h0000};
                    default: d.imm32 = {16'h0000, inst[15:0]};
                endcase
            end else begin
                d.sr2   = inst[17:14];
                d.imm32 = '0;
            end
        end
        return d;
    endfunction

    always_comb begin
        dec_in     = decode(i_buf_pc, i_buf_inst);
        in_valid   = dec_in.valid && !stall_q;
        state_next = state;
        out_next   = out_q;
        skid_next  = skid_q;
        stall_next = stall_q;
        if (i_pipe_flush) begin
            state_next = EMPTY_SKID;
            out_next   = '0;
            skid_next  = '0;
            stall_next = 1'b0;
        end else begin
            case (state)
                EMPTY_SKID: begin
                    // A held bubble is not real work, so a stall only parks valid output.
                    if (!i_pipe_stall || !out_q.valid) begin
                        out_next = in_valid ? dec_in : '0;
                    end else if (in_valid) begin
                        skid_next  = dec_in;
                        stall_next = 1'b1;
                        state_next = FULL_SKID;
                    end
                end
                FULL_SKID: begin
                    if (!i_pipe_stall) begin
                        out_next   = skid_q;
                        skid_next  = '0;
                        stall_next = 1'b0;
                        state_next = EMPTY_SKID;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= EMPTY_SKID;
            out_q   <= '0;
            skid_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_next;
            out_q   <= out_next;
            skid_q  <= skid_next;
            stall_q <= stall_next;
        end
    end

    assign o_pipe_stall = stall_q;
    assign o_dr_valid   = out_q.valid;
    assign o_dr_pc      = out_q.pc;
    assign o_dr_opcode  = out_q.opcode;
    assign o_dr_imode   = out_q.imode;
    assign o_dr_dr      = out_q.dr;
    assign o_dr_sr1     = out_q.sr1;
    assign o_dr_sr2     = out_q.sr2;
    assign o_dr_imm32   = out_q.imm32;
    assign o_dr_illegal = out_q.illegal;

endmodule

// File: tb/tb_tl45_decode_skid.sv
// Directed + random-stall bench for tl45_decode_skid; a scoreboard tracks accepted words
// and checks them, in order, as downstream consumes them.
module tb_tl45_decode_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush;
    logic [31:0] pc, inst;

    logic        o_pipe_stall, a_valid, a_imode, a_illegal;
    logic [31:0] a_pc, a_imm32;
    logic [4:0]  a_opcode;
    logic [3:0]  a_dr, a_sr1, a_sr2;

    logic        b_pipe_stall, b_valid, b_imode, b_illegal;
    logic [31:0] b_pc, b_imm32;
    logic [4:0]  b_opcode;
    logic [3:0]  b_dr, b_sr1, b_sr2;

    tl45_decode_skid #(.OP_ILLEGAL_MIN(5'h18), .BUBBLE_ON_ILLEGAL(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_pipe_stall(stall), .i_pipe_flush(flush),
        .o_pipe_stall(o_pipe_stall), .i_buf_pc(pc), .i_buf_inst(inst),
        .o_dr_valid(a_valid), .o_dr_pc(a_pc), .o_dr_opcode(a_opcode), .o_dr_imode(a_imode),
        .o_dr_dr(a_dr), .o_dr_sr1(a_sr1), .o_dr_sr2(a_sr2), .o_dr_imm32(a_imm32),
        .o_dr_illegal(a_illegal)
    );

    tl45_decode_skid #(.OP_ILLEGAL_MIN(5'h18), .BUBBLE_ON_ILLEGAL(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_pipe_stall(stall), .i_pipe_flush(flush),
        .o_pipe_stall(b_pipe_stall), .i_buf_pc(pc), .i_buf_inst(inst),
        .o_dr_valid(b_valid), .o_dr_pc(b_pc), .o_dr_opcode(b_opcode), .o_dr_imode(b_imode),
        .o_dr_dr(b_dr), .o_dr_sr1(b_sr1), .o_dr_sr2(b_sr2), .o_dr_imm32(b_imm32),
        .o_dr_illegal(b_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic        imode;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm32;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        tk;
    logic [31:0] words[$];
    int          idx;

    function automatic exp_t ref_decode(input logic [31:0] p, input logic [31:0] w);
        exp_t e;
        e.pc      = p;
        e.opcode  = w[31:27];
        e.imode   = w[26];
        e.dr      = w[25:22];
        e.sr1     = w[21:18];
        e.illegal = (w[31:27] >= 5'h18);
        e.sr2     = w[26] ? 4'h0 : w[17:14];
        e.imm32   = 32'h0;
        if (w[26]) begin
            if (w[17:16] == 2'b01)      e.imm32 = {{16{w[15]}}, w[15:0]};
            else if (w[17:16] == 2'b10) e.imm32 = {w[15:0], 16'h0};
            else                        e.imm32 = {16'h0, w[15:0]};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_word(input exp_t got, input exp_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL sb_word: got %h expected %h", got, exp);
        end
    endtask

    // One clock: drive inputs, consume/compare the visible output, track acceptance.
    task automatic step(input logic s, input logic f, input logic [31:0] p, input logic [31:0] w,
                        output logic taken);
        exp_t e, g;
        stall = s; flush = f; pc = p; inst = w;
        taken = !o_pipe_stall;
        if (!rst) begin
            if (a_valid && !s) begin
                if (sb.size() == 0) begin
                    check("spurious_out", {31'b0, a_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    g = '{a_pc, a_opcode, a_imode, a_dr, a_sr1, a_sr2, a_imm32, a_illegal};
                    check_word(g, e);
                end
            end
            if (f) sb.delete();
            else if (taken && w != 32'h0) sb.push_back(ref_decode(p, w));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            stall = 1'b1; flush = $urandom_range(0, 1) == 1; pc = $urandom; inst = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pc = '0; inst = '0;
        @(posedge clk); #1;

        // 1: reset with garbage inputs
        do_reset();
        check("rst_valid", {31'b0, a_valid}, 32'h0);
        check("rst_pc", a_pc, 32'h0);
        check("rst_imm", a_imm32, 32'h0);
        check("rst_stall", {31'b0, o_pipe_stall}, 32'h0);
        check("rst_b_valid", {31'b0, b_valid}, 32'h0);

        // 2: immediate modes and imode=0 field split
        step(0, 0, 32'h100, 32'h0401FFF0, tk);
        check("t2_valid", {31'b0, a_valid}, 32'h1);
        check("t2_pc", a_pc, 32'h100);
        check("t2_imm_sext", a_imm32, 32'hFFFF_FFF0);
        check("t2_sr2", {28'b0, a_sr2}, 32'h0);
        step(0, 0, 32'h104, 32'h04840010, tk);
        check("t2_imm_zext", a_imm32, 32'h0000_0010);
        check("t2_dr", {28'b0, a_dr}, 32'h2);
        check("t2_sr1", {28'b0, a_sr1}, 32'h1);
        step(0, 0, 32'h108, 32'h0402ABCD, tk);
        check("t2_imm_hi", a_imm32, 32'hABCD_0000);
        step(0, 0, 32'h10C, 32'h04038001, tk);
        check("t2_imm_m11", a_imm32, 32'h0000_8001);
        step(0, 0, 32'h110, 32'h094DD234, tk);
        check("t2_r_sr2", {28'b0, a_sr2}, 32'h7);
        check("t2_r_imm", a_imm32, 32'h0);
        check("t2_r_opc", {27'b0, a_opcode}, 32'h1);
        step(0, 0, 32'h0, 32'h0, tk);
        check("t2_bubble", {31'b0, a_valid}, 32'h0);

        // 3: A,B,C with a 3-cycle downstream stall while A is held
        step(0, 0, 32'hA0, 32'h0840_0001, tk);
        step(1, 0, 32'hB0, 32'h0880_0002, tk);
        check("t3_stall_up", {31'b0, o_pipe_stall}, 32'h1);
        step(1, 0, 32'hC0, 32'h08C0_0003, tk);
        step(1, 0, 32'hC0, 32'h08C0_0003, tk);
        check("t3_hold_a", a_pc, 32'hA0);
        check("t3_stall_hold", {31'b0, o_pipe_stall}, 32'h1);
        step(0, 0, 32'hC0, 32'h08C0_0003, tk);
        check("t3_out_b", a_pc, 32'hB0);
        check("t3_stall_down", {31'b0, o_pipe_stall}, 32'h0);
        step(0, 0, 32'hC0, 32'h08C0_0003, tk);
        check("t3_out_c", a_pc, 32'hC0);
        step(0, 0, 32'h0, 32'h0, tk);
        check("t3_sb_empty", sb.size(), 32'h0);

        // 4: flush together with stall while the skid is full
        step(0, 0, 32'hD0, 32'h0900_0004, tk);
        step(1, 0, 32'hD4, 32'h0940_0005, tk);
        check("t4_full", {31'b0, o_pipe_stall}, 32'h1);
        step(1, 1, 32'hD8, 32'h0980_0006, tk);
        check("t4_valid", {31'b0, a_valid}, 32'h0);
        check("t4_pc", a_pc, 32'h0);
        check("t4_stall", {31'b0, o_pipe_stall}, 32'h0);
        step(0, 0, 32'hDC, 32'h09C0_0007, tk);
        check("t4_next_pc", a_pc, 32'hDC);
        check("t4_next_valid", {31'b0, a_valid}, 32'h1);
        step(0, 0, 32'h0, 32'h0, tk);
        step(0, 0, 32'h0, 32'h0, tk);
        check("t4_sb_empty", sb.size(), 32'h0);

        // 5: illegal opcodes on both parameterisations
        do_reset();
        step(0, 0, 32'h200, 32'hD000_0123, tk);
        check("t5_a_valid", {31'b0, a_valid}, 32'h1);
        check("t5_a_illegal", {31'b0, a_illegal}, 32'h1);
        check("t5_b_valid", {31'b0, b_valid}, 32'h0);
        check("t5_b_illegal", {31'b0, b_illegal}, 32'h0);
        step(0, 0, 32'h204, 32'hB800_0001, tk);
        check("t5_17_a_illegal", {31'b0, a_illegal}, 32'h0);
        check("t5_17_b_valid", {31'b0, b_valid}, 32'h1);
        step(0, 0, 32'h208, 32'hC000_0001, tk);
        check("t5_18_a_illegal", {31'b0, a_illegal}, 32'h1);
        check("t5_18_b_valid", {31'b0, b_valid}, 32'h0);
        step(0, 0, 32'h0, 32'h0, tk);

        // 6: alternating bubbles and words under random stall
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[31:27] = 5'($urandom_range(0, 23));
            if (w == 32'h0) w = 32'h1;
            words.push_back((i % 2 == 0) ? 32'h0 : w);
        end
        idx = 0;
        for (int cyc = 0; cyc < 400 && idx < words.size(); cyc++) begin
            step($urandom_range(0, 9) < 4, 0, 32'h1000 + 32'(idx * 4), words[idx], tk);
            if (tk) idx++;
        end
        check("t6_stream_done", idx, words.size());
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) step(0, 0, 32'h0, 32'h0, tk);
        check("t6_sb_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
